// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the receive-side PWL filter controller.
package filter_package;

  localparam int NUM_UI           = 16;
  localparam int NUM_RX_SETTINGS  = 4;
  localparam int RX_SETTING_WIDTH = 2;
  localparam int PWL_ROM_LATENCY  = 1;

  // One extra cycle covers the delayed value-history write ahead of the ROM.
  localparam int FILTER_SETTLE_CYCLES = PWL_ROM_LATENCY + 1;
  localparam int FILL_CNT_WIDTH       = $clog2(NUM_UI + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    PEND   = 2'd2,
    SETTLE = 2'd3
  } FILTER_CTRL_STATE;

endpackage

// File: rtl/filter_ctrl_if.sv
// Host/config side handshake and filter-facing status of the filter controller.
interface filter_ctrl_if
  import filter_package::*;
#(
  parameter int SETTING_WIDTH = RX_SETTING_WIDTH
);

  logic                     time_eq_in;
  logic [SETTING_WIDTH-1:0] req_setting;
  logic                     req_valid;
  logic                     req_ready;
  logic [SETTING_WIDTH-1:0] rx_setting;
  logic                     out_valid;
  logic                     busy;
  logic                     err;

  modport master (
    output time_eq_in, req_setting, req_valid,
    input  req_ready, rx_setting, out_valid, busy, err
  );

  modport slave (
    input  time_eq_in, req_setting, req_valid,
    output req_ready, rx_setting, out_valid, busy, err
  );

endinterface

// File: rtl/filter_ctrl_sat_event_counter.sv
// Event counter that saturates at MAX_COUNT; clear has priority over increment.
module sat_event_counter #(
  parameter int MAX_COUNT = 16,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat;

  assign sat = (cnt_q == WIDTH'(MAX_COUNT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat;

endmodule

// File: rtl/filter_ctrl.sv
// Owns rx_setting for the PWL filter, applies setting changes between input
// events and marks the cycles in which the filter output can be trusted.
module filter_ctrl
  import filter_package::*;
#(
  parameter int N_UI            = NUM_UI,
  parameter int N_SETTINGS      = NUM_RX_SETTINGS,
  parameter int SETTING_WIDTH   = RX_SETTING_WIDTH,
  parameter int DEFAULT_SETTING = 0,
  parameter int PWL_LATENCY     = PWL_ROM_LATENCY,
  parameter bit FLUSH_ON_CHANGE = 1'b1
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  filter_ctrl_if.slave bus
);

  localparam int CW            = $clog2(N_UI + 1);
  localparam int SETTLE_CYCLES = PWL_LATENCY + 1;
  localparam int SW            = $clog2(SETTLE_CYCLES + 1);

  FILTER_CTRL_STATE         state_q, state_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [SETTING_WIDTH-1:0] rx_setting_q, rx_setting_d;
  logic [SETTING_WIDTH-1:0] pend_setting_q, pend_setting_d;
  logic                     req_ready_q, out_valid_q, busy_q, err_q;

  logic [CW-1:0]            fill_cnt;
  logic                     fill_sat;
  logic                     accept, req_in_range, req_ok, apply, fill_clr;

  assign accept       = bus.req_valid && req_ready_q;
  assign req_in_range = int'(bus.req_setting) < N_SETTINGS;
  assign req_ok       = accept && req_in_range;
  assign apply        = (state_q == PEND) && !bus.time_eq_in;
  assign fill_clr     = apply && FLUSH_ON_CHANGE;

  sat_event_counter #(
    .MAX_COUNT (N_UI),
    .WIDTH     (CW)
  ) u_fill_cnt (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .inc_i (bus.time_eq_in),
    .clr_i (fill_clr),
    .cnt_o (fill_cnt),
    .sat_o (fill_sat)
  );

  // A request wins over the FILL->SETTLE transition; the event is still counted.
  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    rx_setting_d   = rx_setting_q;
    pend_setting_d = pend_setting_q;
    unique case (state_q)
      FILL: begin
        if (req_ok) begin
          pend_setting_d = bus.req_setting;
          state_d        = PEND;
        end else if (fill_sat || (bus.time_eq_in && fill_cnt == CW'(N_UI - 1))) begin
          settle_d = SW'(SETTLE_CYCLES);
          state_d  = SETTLE;
        end
      end
      RUN: begin
        if (req_ok) begin
          pend_setting_d = bus.req_setting;
          state_d        = PEND;
        end
      end
      PEND: begin
        if (apply) begin
          rx_setting_d = pend_setting_q;
          settle_d     = SW'(SETTLE_CYCLES);
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q <= SW'(1)) begin
          settle_d = '0;
          state_d  = fill_sat ? RUN : FILL;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q        <= FILL;
      settle_q       <= '0;
      rx_setting_q   <= SETTING_WIDTH'(DEFAULT_SETTING);
      pend_setting_q <= '0;
      req_ready_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      rx_setting_q   <= rx_setting_d;
      pend_setting_q <= pend_setting_d;
      req_ready_q    <= (state_d == FILL) || (state_d == RUN);
      out_valid_q    <= (state_d == RUN);
      busy_q         <= (state_d == PEND) || (state_d == SETTLE);
      err_q          <= accept && !req_in_range;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rx_setting = rx_setting_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: doc/filter_ctrl.md
Name: filter_ctrl

Overview:
Sequences the receive-side PWL filter.
- Owns the rx_setting register that selects the filter's PWL ROM bank.
- Accepts setting-change requests over a valid/ready handshake and applies them only in cycles with no input event.
- Tracks history fill and PWL/value-history latency, and drives out_valid to mark cycles in which the filter output is meaningful.
- Sits between the emulator's host/config register block and the filter instance; shares clk_sys and time_eq_in with it.

Parameters:
N_UI, 16, filter history depth (equals NUM_UI of the filter)
N_SETTINGS, 4, number of valid rx settings (ROM banks)
SETTING_WIDTH, 2, width of rx_setting
DEFAULT_SETTING, 0, rx_setting value after reset
PWL_LATENCY, 1, registered cycles through the PWL ROM lookup
FLUSH_ON_CHANGE, 1, 1 = a setting change restarts history fill; 0 = settle only

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
rst_n  in  1  synchronous, active-low reset
time_eq_in  in  1  filter input-event strobe (same net as the filter's time_eq_in)
req_setting  in  SETTING_WIDTH  requested rx setting
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
rx_setting  out  SETTING_WIDTH  setting driven to the filter, registered
out_valid  out  1  filter output is valid this cycle
busy  out  1  high in PEND or SETTLE
err  out  1  one-cycle pulse when an out-of-range request is dropped

Behaviour:
- Reset (rst_n=0 at a clk_sys edge) produces the following values:
  - state=FILL, fill_cnt=0, settle_cnt=0, pend_setting=0
  - rx_setting=DEFAULT_SETTING, out_valid=0, err=0, busy=0, req_ready=0
- A reset asserted mid-operation discards any pending request.
- req_ready=1 in FILL and RUN, 0 in PEND and SETTLE, registered.
- Accept occurs when req_valid && req_ready.
  - If req_setting >= N_SETTINGS: pulse err next cycle, keep state, rx_setting unchanged.
  - Otherwise latch pend_setting and go to PEND.
- fill_cnt:
  - Width $clog2(N_UI+1).
  - Increments on time_eq_in in every state except after saturation; saturates at N_UI.
  - Counts in PEND and SETTLE too.
- FILL:
  - When time_eq_in occurs with fill_cnt==N_UI-1, go to SETTLE with settle_cnt=PWL_LATENCY+1 (covers the delayed value-history write plus ROM latency).
  - If N_UI events are already counted on entry (FLUSH_ON_CHANGE=0 path), go directly to SETTLE.
- SETTLE:
  - Decrement settle_cnt each cycle; at 1, go to RUN (if fill_cnt==N_UI) or FILL.
  - Events during SETTLE are counted but do not restart settle.
- RUN:
  - out_valid=1, registered: high the cycle after entering RUN, low the cycle after leaving.
  - An accepted request goes to PEND.
- PEND:
  - Apply only in a cycle where time_eq_in==0: rx_setting<=pend_setting.
  - If FLUSH_ON_CHANGE, fill_cnt<=0 and the next state is FILL after settle; otherwise fill_cnt is held.
  - Always go to SETTLE with settle_cnt=PWL_LATENCY+1.
  - While time_eq_in==1, remain in PEND (no starvation bound; the testbench must guarantee gaps).
- Request of the current value is processed identically (re-settle, optional flush).
- Simultaneous accept and time_eq_in in FILL or RUN: the event is counted and the request is latched in the same cycle.
- busy = (state==PEND || state==SETTLE), registered alongside state.

Decomposition:
- Put the following in filter_package:
  - the FILTER_CTRL_STATE enum {FILL, RUN, PEND, SETTLE}
  - FILTER_SETTLE_CYCLES = PWL_LATENCY+1
  - FILL_CNT_WIDTH = $clog2(NUM_UI+1)
- Parameter defaults are taken from NUM_UI, NUM_RX_SETTINGS, RX_SETTING_WIDTH.
- One natural sub-module: sat_event_counter, a saturating counter with increment, clear and saturate-at-N. It is used for fill_cnt; settle_cnt stays inline.

Test Plan:
- Reset, then 16 time_eq_in pulses spaced 3 cycles apart: out_valid=0 through the 16th pulse and rises 3 cycles after it (PWL_LATENCY=1); rx_setting=0 throughout.
- In RUN, req_setting=2 with req_valid for 1 cycle and time_eq_in low: rx_setting=2 on the second edge after accept; busy high for 3 cycles; out_valid low until 16 further events plus settle (FLUSH_ON_CHANGE=1).
- Same request with time_eq_in held high for 5 cycles after accept: rx_setting stays unchanged for those 5 cycles and updates on the first quiet cycle.
- req_setting=3 with N_SETTINGS=3: err pulses once; state, rx_setting and out_valid unchanged; req_ready remains 1.
- Accept coinciding with time_eq_in at fill_cnt=15 in FILL: the event is counted (fill_cnt=16), the controller enters PEND, and the later apply clears fill_cnt to 0.
- rst_n low for 1 cycle during SETTLE: the next cycle shows rx_setting=DEFAULT_SETTING, out_valid=0, busy=0, fill_cnt=0, and the pending request is dropped.
